md_ctrl: RTL and testbench

Sequencer for the HI/LO multiply/divide datapath. It sits beside the EX stage and turns decoded EX-stage mult/div/mthi/mtlo operations into load, write and commit strobes for the datapath. It times the multi-cycle latency, raises `busy`, and produces the ID-stage stall for any HI/LO-class instruction. It also freezes in-flight work while an exception request is pending.

---
 rtl/md_pkg.sv | 58 +++++
 rtl/md_down_counter.sv | 35 +++
 rtl/md_ctrl.sv | 121 ++++++++++++
 tb/tb_md_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the HI/LO multiply/divide sequencer.
// Holds the EX-stage op encoding used by decode, md_ctrl and the HI/LO
// datapath, the sequencer state encoding, default latencies, and a helper
// that classifies the long-latency ops.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;
  localparam int CNT_W_DEF    = 4;

  // True for the ops that occupy the multi-cycle datapath.
  function automatic logic is_muldiv(input md_op_e op);
    logic r;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the divide flavours; selects latency and the md_is_div qualifier.
  function automatic logic is_div(input md_op_e op);
    logic r;
    case (op)
      MD_DIV, MD_DIVU: r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the signed flavours (MULT, DIV).
  function automatic logic is_signed_op(input md_op_e op);
    logic r;
    case (op)
      MD_MULT, MD_DIV: r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_down_counter.sv
// md_down_counter: loadable, enable-gated down-counter for md_ctrl latency.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset, clears the count
//   load       - load load_val this edge (has priority over en)
//   load_val   - initial count
//   en         - decrement this edge
//   cnt_is_one - count currently equals one (last cycle of an operation)
module md_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             cnt_is_one
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: load wins over decrement, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt_is_one = (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: sequencer for the HI/LO multiply/divide datapath.
// Turns EX-stage mult/div/mthi/mtlo into datapath strobes, times the
// multi-cycle latency, and generates the ID stall for HI/LO-class ops.
// Ports:
//   clk, reset          - clock; asynchronous active-low reset
//   ex_valid, ex_op     - EX instruction valid and its md_op_e
//   req                 - exception/interrupt request; freezes the block
//   id_is_md            - ID instruction is a HI/LO-class op
//   md_load             - latch operands and start computing {hi,lo}
//   md_signed/md_is_div - qualifiers for md_load
//   md_wr_hi/md_wr_lo   - direct write of A into HI / LO
//   md_commit           - copy pending {hi,lo} into HI/LO at this edge
//   busy                - operation in flight (registered)
//   stall               - hold IF/ID and bubble EX
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   ex_valid,
  input  md_op_e ex_op,
  input  logic   req,
  input  logic   id_is_md,
  output logic   md_load,
  output logic   md_signed,
  output logic   md_is_div,
  output logic   md_wr_hi,
  output logic   md_wr_lo,
  output logic   md_commit,
  output logic   busy,
  output logic   stall
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

  md_state_e        state_r;
  md_state_e        state_nxt_s;
  logic             busy_r;
  logic             busy_nxt_s;
  logic             idle_s;
  logic             accept_s;
  logic             start_s;
  logic             commit_s;
  logic             cnt_en_s;
  logic             cnt_is_one_s;
  logic [CNT_W-1:0] cnt_load_val_s;

  // req gates every strobe; new work is only taken while IDLE.
  assign idle_s         = (state_r == ST_IDLE);
  assign accept_s       = ex_valid & ~req & idle_s;
  assign start_s        = accept_s & is_muldiv(ex_op);
  assign cnt_en_s       = (state_r == ST_RUN) & ~req;
  assign commit_s       = cnt_en_s & cnt_is_one_s;
  assign cnt_load_val_s = is_div(ex_op) ? DIV_LD : MULT_LD;

  md_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (start_s),
    .load_val   (cnt_load_val_s),
    .en         (cnt_en_s),
    .cnt_is_one (cnt_is_one_s)
  );

  // State register and registered busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Next-state logic: start moves to RUN, the commit cycle returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    busy_nxt_s  = busy_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_RUN;
          busy_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (commit_s) begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // Output decode; stall deliberately ignores req.
  always_comb begin
    md_load   = start_s;
    md_signed = start_s & is_signed_op(ex_op);
    md_is_div = start_s & is_div(ex_op);
    md_wr_hi  = accept_s & (ex_op == MD_MTHI);
    md_wr_lo  = accept_s & (ex_op == MD_MTLO);
    md_commit = commit_s;
    busy      = busy_r;
    stall     = id_is_md & (busy_r | start_s);
  end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed self-checking bench for md_ctrl.
// A latency model (in-flight flag plus remaining unfrozen cycles) predicts
// every output each cycle; directed scenarios additionally pin the model
// with hand-computed latencies and strobe counts.
module tb_md_ctrl;
  import md_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  logic   ex_valid = 1'b0;
  md_op_e ex_op = MD_NONE;
  logic   req = 1'b0;
  logic   id_is_md = 1'b0;
  logic   md_load, md_signed, md_is_div, md_wr_hi, md_wr_lo, md_commit, busy, stall;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  md_ctrl dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op), .req(req),
    .id_is_md(id_is_md), .md_load(md_load), .md_signed(md_signed),
    .md_is_div(md_is_div), .md_wr_hi(md_wr_hi), .md_wr_lo(md_wr_lo),
    .md_commit(md_commit), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  logic m_inflight = 1'b0;
  int   m_rem = 0;
  logic m_long, m_start, m_take;
  logic e_load, e_signed, e_div, e_wr_hi, e_wr_lo, e_commit, e_stall;

  always_comb begin
    m_long   = (ex_op == MD_MULT) || (ex_op == MD_MULTU) || (ex_op == MD_DIV) || (ex_op == MD_DIVU);
    m_take   = ex_valid && !req && !m_inflight;
    m_start  = m_take && m_long;
    e_load   = m_start;
    e_signed = m_start && ((ex_op == MD_MULT) || (ex_op == MD_DIV));
    e_div    = m_start && ((ex_op == MD_DIV) || (ex_op == MD_DIVU));
    e_wr_hi  = m_take && (ex_op == MD_MTHI);
    e_wr_lo  = m_take && (ex_op == MD_MTLO);
    e_commit = m_inflight && !req && (m_rem == 1);
    e_stall  = id_is_md && (m_inflight || m_start);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_inflight <= 1'b0;
      m_rem      <= 0;
    end else if (m_start) begin
      m_inflight <= 1'b1;
      m_rem      <= ((ex_op == MD_DIV) || (ex_op == MD_DIVU)) ? 10 : 5;
    end else if (m_inflight && !req) begin
      if (m_rem == 1) m_inflight <= 1'b0;
      m_rem <= m_rem - 1;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("md_load", md_load, e_load);
    chk("md_signed", md_signed, e_signed);
    chk("md_is_div", md_is_div, e_div);
    chk("md_wr_hi", md_wr_hi, e_wr_hi);
    chk("md_wr_lo", md_wr_lo, e_wr_lo);
    chk("md_commit", md_commit, e_commit);
    chk("busy", busy, m_inflight);
    chk("stall", stall, e_stall);
    if (m_inflight && ex_valid && (ex_op != MD_NONE)) begin
      errors++;
      $display("FAIL ex_md_during_run cycle %0d: op %0d in EX while busy", cyc, ex_op);
    end
  end

  // ---------------- measurement for literal checks ----------------
  int load_cyc, commit_cyc, commit_cnt, load_cnt, busy_cnt, stall_cnt, wr_hi_cnt, wr_lo_cnt;
  logic load_div, load_signed;

  always @(negedge clk) begin
    if (md_load) begin
      load_cyc    = cyc;
      load_cnt    = load_cnt + 1;
      load_div    = md_is_div;
      load_signed = md_signed;
    end
    if (md_commit) begin
      commit_cyc = cyc;
      commit_cnt = commit_cnt + 1;
    end
    if (busy) busy_cnt = busy_cnt + 1;
    if (stall) stall_cnt = stall_cnt + 1;
    if (md_wr_hi) wr_hi_cnt = wr_hi_cnt + 1;
    if (md_wr_lo) wr_lo_cnt = wr_lo_cnt + 1;
  end

  task automatic clr();
    load_cyc = -100; commit_cyc = -1; commit_cnt = 0; load_cnt = 0;
    busy_cnt = 0; stall_cnt = 0; wr_hi_cnt = 0; wr_lo_cnt = 0;
    load_div = 1'b0; load_signed = 1'b0;
  endtask

  // One cycle of stimulus, applied just after the rising edge.
  task automatic drive(input logic v, input md_op_e op, input logic r, input logic id);
    ex_valid = v; ex_op = op; req = r; id_is_md = id;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, MD_NONE, 1'b0, 1'b0);
  endtask

  initial begin
    clr();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    id_is_md = 1'b1;
    #1;
    lit("rst_busy", int'(busy), 0);
    lit("rst_load", int'(md_load), 0);
    lit("rst_stall", int'(stall), 0);
    id_is_md = 1'b0;
    reset = 1'b1;
    idle(2);

    // MULT, no req: commit 5 cycles after load, busy for 5 cycles
    clr();
    drive(1'b1, MD_MULT, 1'b0, 1'b0);
    idle(7);
    lit("mult_latency", commit_cyc - load_cyc, 5);
    lit("mult_busy_cycles", busy_cnt, 5);
    lit("mult_commits", commit_cnt, 1);
    lit("mult_signed", int'(load_signed), 1);

    // DIVU with MFLO waiting in ID: 11 stalled cycles
    clr();
    drive(1'b1, MD_DIVU, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) drive(1'b0, MD_NONE, 1'b0, 1'b1);
    lit("divu_stall_cycles", stall_cnt, 11);
    lit("divu_is_div", int'(load_div), 1);
    lit("divu_signed", int'(load_signed), 0);
    lit("divu_latency", commit_cyc - load_cyc, 10);
    idle(1);

    // MULT, req high for cycles 2..4: commit moves to cycle 8
    clr();
    drive(1'b1, MD_MULT, 1'b0, 1'b0);
    drive(1'b0, MD_NONE, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, MD_NONE, 1'b1, 1'b0);
    idle(6);
    lit("req_latency", commit_cyc - load_cyc, 8);
    lit("req_busy_cycles", busy_cnt, 8);

    // MTLO / MTHI while idle, MFLO in ID not stalled
    clr();
    drive(1'b1, MD_MTLO, 1'b0, 1'b0);
    drive(1'b0, MD_NONE, 1'b0, 1'b1);
    drive(1'b1, MD_MTHI, 1'b0, 1'b0);
    drive(1'b1, MD_MTHI, 1'b1, 1'b0);
    idle(2);
    lit("mtlo_writes", wr_lo_cnt, 1);
    lit("mthi_writes", wr_hi_cnt, 1);
    lit("mt_busy", busy_cnt, 0);
    lit("mt_stall", stall_cnt, 0);

    // Back-to-back MULTs: second one enters EX after busy falls
    clr();
    drive(1'b1, MD_MULT, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, MD_NONE, 1'b0, 1'b1);
    drive(1'b1, MD_MULTU, 1'b0, 1'b0);
    idle(6);
    lit("b2b_commits", commit_cnt, 2);
    lit("b2b_second_load_after_commit", load_cyc, commit_cyc - 5);

    // DIV abandoned by reset at cycle 4, then a normal MULT
    clr();
    drive(1'b1, MD_DIV, 1'b0, 1'b0);
    idle(3);
    #2 reset = 1'b0;
    #1;
    lit("async_reset_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    idle(1);
    reset = 1'b1;
    idle(12);
    lit("reset_no_commit", commit_cnt, 0);
    clr();
    drive(1'b1, MD_MULT, 1'b0, 1'b0);
    idle(7);
    lit("post_reset_latency", commit_cyc - load_cyc, 5);

    // MULT with req in the same cycle: flushed, nothing starts
    clr();
    drive(1'b1, MD_MULT, 1'b1, 1'b0);
    idle(4);
    lit("req_flush_load", load_cnt, 0);
    lit("req_flush_busy", busy_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
